// File: rtl/icache_param.sv
`default_nettype none
// icache_param: parametrised direct-mapped instruction cache with multi-word line fill,
// invalidate-all flush and saturating hit/miss counters.
module icache_param #(
    parameter int WORD_W = 32,
    parameter int IDX_W  = 4,
    parameter int BLK_W  = 1,
    parameter int BYT_W  = 2,
    parameter int TAG_W  = WORD_W - IDX_W - BLK_W - BYT_W,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              imemREN,
    input  logic [WORD_W-1:0] imemaddr,
    input  logic              iflush,
    output logic              ihit,
    output logic [WORD_W-1:0] imemload,
    output logic              iREN,
    output logic [WORD_W-1:0] iaddr,
    input  logic              iwait,
    input  logic [WORD_W-1:0] iload,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);
    localparam int SETS  = 1 << IDX_W;
    localparam int WORDS = 1 << BLK_W;
    localparam int PTR_W = IDX_W + BLK_W;
    localparam int FC_W  = (BLK_W > 0) ? BLK_W : 1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t state, state_n;

    logic [TAG_W-1:0]  tags [SETS];
    logic [WORD_W-1:0] data [SETS*WORDS];
    logic [SETS-1:0]   valid;
    logic [TAG_W-1:0]  fill_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [FC_W-1:0]   fill_cnt, fill_cnt_n;

    logic [TAG_W-1:0]          req_tag;
    logic [IDX_W-1:0]          req_idx;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W-1:0]          wr_ptr;
    logic [WORD_W-BYT_W-1:0]   fill_word_addr;
    logic                      last_word;
    logic                      lookup_hit;
    logic                      start_fill;
    logic                      accept;
    logic                      fill_done;

    assign req_tag    = imemaddr[WORD_W-1 -: TAG_W];
    assign req_idx    = imemaddr[BYT_W+BLK_W +: IDX_W];
    assign lookup_hit = valid[req_idx] && (tags[req_idx] == req_tag);

    // Block offset only exists for multi-word lines; single-word lines index by set alone.
    if (BLK_W > 0) begin : g_blk
        assign rd_ptr         = {req_idx, imemaddr[BYT_W +: BLK_W]};
        assign wr_ptr         = {fill_idx, fill_cnt};
        assign last_word      = (fill_cnt == FC_W'(WORDS - 1));
        assign fill_word_addr = {fill_tag, fill_idx, fill_cnt};
    end else begin : g_noblk
        logic unused_cnt;
        assign unused_cnt     = ^fill_cnt;
        assign rd_ptr         = req_idx;
        assign wr_ptr         = fill_idx;
        assign last_word      = 1'b1;
        assign fill_word_addr = {fill_tag, fill_idx};
    end

    if (BYT_W > 0) begin : g_byte
        logic unused_byte;
        assign unused_byte = ^imemaddr[BYT_W-1:0];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            fill_cnt <= '0;
        end else begin
            state    <= state_n;
            fill_cnt <= fill_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        fill_cnt_n = fill_cnt;
        start_fill = 1'b0;
        accept     = 1'b0;
        fill_done  = 1'b0;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        case (state)
            IDLE: begin
                ihit = imemREN && !iflush && lookup_hit;
                if (ihit) begin
                    imemload = data[rd_ptr];
                end
                if (imemREN && !iflush && !lookup_hit) begin
                    start_fill = 1'b1;
                    fill_cnt_n = '0;
                    state_n    = FILL;
                end
            end
            FILL: begin
                iREN  = 1'b1;
                iaddr = WORD_W'(fill_word_addr) << BYT_W;
                // Flush abandons the partial line; it is never marked valid.
                if (iflush) begin
                    state_n = IDLE;
                end else if (!iwait) begin
                    accept     = 1'b1;
                    fill_cnt_n = fill_cnt + 1'b1;
                    if (last_word) begin
                        fill_done = 1'b1;
                        state_n   = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid    <= '0;
            fill_tag <= '0;
            fill_idx <= '0;
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (iflush) begin
                valid <= '0;
            end else if (fill_done) begin
                valid[fill_idx] <= 1'b1;
            end
            if (start_fill) begin
                fill_tag <= req_tag;
                fill_idx <= req_idx;
            end
            if (ihit && (hit_cnt != '1)) begin
                hit_cnt <= hit_cnt + 1'b1;
            end
            if (start_fill && (miss_cnt != '1)) begin
                miss_cnt <= miss_cnt + 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (accept) begin
            data[wr_ptr] <= iload;
        end
        if (fill_done) begin
            tags[fill_idx] <= fill_tag;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_param.sv
`default_nettype none
// Scoreboard bench for icache_param: default instance, single-word-block instance
// (IDX_W=3, BLK_W=0) and a 4-bit-counter instance, each with its own memory latency.
module tb_icache_param;
    logic CLK = 1'b0;
    logic nRST;

    logic        ren      [3];
    logic [31:0] addr     [3];
    logic        flush    [3];
    logic        ihit     [3];
    logic [31:0] imemload [3];
    logic        iREN     [3];
    logic [31:0] iaddr    [3];
    logic        iwait    [3];
    logic [31:0] iload    [3];
    logic [15:0] hcnt     [2];
    logic [15:0] mcnt     [2];
    logic [3:0]  hc4, mc4;
    int          wcnt     [3];

    logic [33:0] sb_req [$];
    logic [33:0] sb_hit [$];
    int n_checks = 0;
    int n_errors = 0;

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 2 : ((d == 1) ? 3 : 1);
    endfunction

    function automatic int words_of(input int d);
        return (d == 1) ? 1 : 2;
    endfunction

    task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    icache_param u_dut0 (
        .CLK(CLK), .nRST(nRST), .imemREN(ren[0]), .imemaddr(addr[0]), .iflush(flush[0]),
        .ihit(ihit[0]), .imemload(imemload[0]), .iREN(iREN[0]), .iaddr(iaddr[0]),
        .iwait(iwait[0]), .iload(iload[0]), .hit_cnt(hcnt[0]), .miss_cnt(mcnt[0])
    );

    icache_param #(.IDX_W(3), .BLK_W(0)) u_dut1 (
        .CLK(CLK), .nRST(nRST), .imemREN(ren[1]), .imemaddr(addr[1]), .iflush(flush[1]),
        .ihit(ihit[1]), .imemload(imemload[1]), .iREN(iREN[1]), .iaddr(iaddr[1]),
        .iwait(iwait[1]), .iload(iload[1]), .hit_cnt(hcnt[1]), .miss_cnt(mcnt[1])
    );

    icache_param #(.CNT_W(4)) u_dut2 (
        .CLK(CLK), .nRST(nRST), .imemREN(ren[2]), .imemaddr(addr[2]), .iflush(flush[2]),
        .ihit(ihit[2]), .imemload(imemload[2]), .iREN(iREN[2]), .iaddr(iaddr[2]),
        .iwait(iwait[2]), .iload(iload[2]), .hit_cnt(hc4), .miss_cnt(mc4)
    );

    // Memory model: each word is presented lat_of(d) cycles after its request appears.
    always_comb begin
        for (int d = 0; d < 3; d++) begin
            iwait[d] = !(iREN[d] && (wcnt[d] == lat_of(d) - 1));
            iload[d] = mem(iaddr[d]);
        end
    end

    always @(posedge CLK) begin
        for (int d = 0; d < 3; d++) begin
            if (iREN[d]) wcnt[d] <= (wcnt[d] == lat_of(d) - 1) ? 0 : wcnt[d] + 1;
            else         wcnt[d] <= 0;
        end
    end

    // Scoreboard consumer: every accepted memory word and every hit pops one expectation.
    always @(negedge CLK) begin
        logic [33:0] e;
        for (int d = 0; d < 3; d++) begin
            if (iREN[d] && !iwait[d]) begin
                e = (sb_req.size() != 0) ? sb_req.pop_front() : 34'h3_FFFF_FFFF;
                check("iaddr", {d[1:0], iaddr[d]}, e);
            end
            if (ihit[d]) begin
                e = (sb_hit.size() != 0) ? sb_hit.pop_front() : 34'h3_FFFF_FFFF;
                check("imemload", {d[1:0], imemload[d]}, e);
            end
        end
    end

    task automatic access(input int d, input logic [31:0] a, input bit miss);
        int          cyc;
        logic [31:0] base;
        if (miss) begin
            base = a & ~(32'(words_of(d) * 4) - 32'd1);
            for (int i = 0; i < words_of(d); i++) begin
                sb_req.push_back({d[1:0], base + 32'(4 * i)});
            end
        end
        sb_hit.push_back({d[1:0], mem(a & ~32'h3)});
        @(posedge CLK); #1;
        ren[d]  = 1'b1;
        addr[d] = a;
        cyc = 0;
        do begin
            @(negedge CLK); #1;
            cyc++;
            if (!miss && cyc == 1) check("hit_iren", 34'(iREN[d]), 34'd0);
        end while (!ihit[d] && cyc < 40);
        check(miss ? "miss_lat" : "hit_lat", 34'(cyc), miss ? 34'(2 + words_of(d) * lat_of(d)) : 34'd1);
        @(posedge CLK); #1;
        ren[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            ren[d] = 1'b0; addr[d] = 32'h0; flush[d] = 1'b0;
        end
        nRST = 1'b1;
        #1 nRST = 1'b0;
        #2;
        check("rst_ihit",  34'(ihit[0]),     34'd0);
        check("rst_iren",  34'(iREN[0]),     34'd0);
        check("rst_iaddr", 34'(iaddr[0]),    34'd0);
        check("rst_load",  34'(imemload[0]), 34'd0);
        check("rst_hcnt",  34'(hcnt[0]),     34'd0);
        check("rst_mcnt",  34'(mcnt[0]),     34'd0);
        @(posedge CLK); #1 nRST = 1'b1;

        // Cold miss, two-word fill, then same-line hit
        access(0, 32'h40, 1'b1);
        check("t1_mcnt", 34'(mcnt[0]), 34'd1);
        check("t1_hcnt", 34'(hcnt[0]), 34'd1);
        access(0, 32'h44, 1'b0);
        check("t2_hcnt", 34'(hcnt[0]), 34'd2);

        // Conflict in set 8 evicts 0x40
        access(0, 32'h440, 1'b1);
        access(0, 32'h40, 1'b1);
        check("t3_mcnt", 34'(mcnt[0]), 34'd3);

        // Flush on a would-be hit: no hit, no fill
        @(posedge CLK); #1;
        ren[0] = 1'b1; addr[0] = 32'h40; flush[0] = 1'b1;
        @(negedge CLK); #1;
        check("flush_nohit", 34'(ihit[0]), 34'd0);
        @(posedge CLK); #1;
        ren[0] = 1'b0; flush[0] = 1'b0;
        @(negedge CLK); #1;
        check("flush_nofill", 34'(iREN[0]), 34'd0);

        // Flush on the 2nd fill cycle of 0x80 aborts the fill
        @(posedge CLK); #1;
        ren[0] = 1'b1; addr[0] = 32'h80;
        sb_req.push_back({2'd0, 32'h80});
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        flush[0] = 1'b1; ren[0] = 1'b0;
        @(negedge CLK); #1;
        check("abort_ihit", 34'(ihit[0]), 34'd0);
        @(posedge CLK); #1;
        flush[0] = 1'b0;
        @(negedge CLK); #1;
        check("abort_iren", 34'(iREN[0]), 34'd0);
        access(0, 32'h40, 1'b1);
        access(0, 32'h80, 1'b1);
        check("t4_mcnt", 34'(mcnt[0]), 34'd6);
        check("t4_hcnt", 34'(hcnt[0]), 34'd6);

        // Single-word blocks, 8 sets
        access(1, 32'h10, 1'b1);
        access(1, 32'h10, 1'b0);
        access(1, 32'h14, 1'b1);
        check("t5_mcnt", 34'(mcnt[1]), 34'd2);
        check("t5_hcnt", 34'(hcnt[1]), 34'd3);

        // 4-bit counter saturation
        access(2, 32'h40, 1'b1);
        for (int i = 0; i < 20; i++) sb_hit.push_back({2'd2, mem(32'h40)});
        @(posedge CLK); #1;
        ren[2] = 1'b1; addr[2] = 32'h40;
        repeat (20) @(posedge CLK);
        #1 ren[2] = 1'b0;
        check("t6_hsat", 34'(hc4), 34'd15);
        check("t6_mcnt", 34'(mc4), 34'd1);

        // Asynchronous reset in the middle of a fill
        @(posedge CLK); #1;
        ren[2] = 1'b1; addr[2] = 32'h80;
        sb_req.push_back({2'd2, 32'h80});
        @(posedge CLK);
        @(negedge CLK); #2;
        nRST = 1'b0;
        #1;
        check("arst_iren",  34'(iREN[2]),     34'd0);
        check("arst_iaddr", 34'(iaddr[2]),    34'd0);
        check("arst_ihit",  34'(ihit[2]),     34'd0);
        check("arst_load",  34'(imemload[2]), 34'd0);
        check("arst_hcnt",  34'(hc4),         34'd0);
        check("arst_mcnt",  34'(mc4),         34'd0);
        ren[2] = 1'b0;
        @(posedge CLK); #1 nRST = 1'b1;
        access(2, 32'h80, 1'b1);
        access(2, 32'h40, 1'b1);
        check("t6_mcnt2", 34'(mc4), 34'd2);

        check("sb_req_left", 34'(sb_req.size()), 34'd0);
        check("sb_hit_left", 34'(sb_hit.size()), 34'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/icache_param.md
Name: icache_param

Overview:
- Parametrised direct-mapped instruction cache. Successor to the fixed 16-set, 1-word-block icache format.
- Generalised in set count and in words per block (multi-word line fill), with flush and hit/miss performance counters added.
- Sits between the fetch stage (imem request side) and the memory controller (instruction read port).

Parameters:
- WORD_W, 32, data/address width
- IDX_W, 4, index bits; sets = 2^IDX_W
- BLK_W, 1, block-offset bits; words per block = 2^BLK_W (0 permitted)
- BYT_W, 2, byte-offset bits, ignored for lookup
- TAG_W, WORD_W-IDX_W-BLK_W-BYT_W, derived tag width
- CNT_W, 16, performance counter width

Ports:
- CLK  in  1  clock, rising edge
- nRST  in  1  asynchronous active-low reset
- imemREN  in  1  fetch read request
- imemaddr  in  WORD_W  fetch address
- iflush  in  1  invalidate-all pulse
- ihit  out  1  imemload valid this cycle
- imemload  out  WORD_W  instruction word
- iREN  out  1  memory read request
- iaddr  out  WORD_W  memory word address
- iwait  in  1  memory not ready; iload valid when iwait=0 and iREN=1
- iload  in  WORD_W  memory read data
- hit_cnt  out  CNT_W  saturating hit count
- miss_cnt  out  CNT_W  saturating miss count

Behaviour:
- Address split: {tag, idx, blkoff, bytoff}, MSB to LSB. Byte offset ignored; unaligned addresses are not an error.
- Reset (async, nRST=0):
  - all valid bits cleared; state IDLE; fill counter 0
  - ihit=0, imemload=0, iREN=0, iaddr=0, hit_cnt=0, miss_cnt=0
  - tag and data arrays need not reset
  - reset mid-fill aborts the fill with no line written valid
- States: IDLE, FILL.
- IDLE:
  - ihit = imemREN & valid[idx] & tag match & !iflush. Combinational, same-cycle hit.
  - imemload = data[idx][blkoff] when ihit, else 0.
  - imemREN=1 and not a hit and iflush=0: latch tag/idx, counter=0, miss_cnt+1, go to FILL.
- FILL:
  - iREN=1; iaddr={latched tag, latched idx, counter, BYT_W'0}.
  - Words are fetched in order 0..N-1 (no critical-word-first).
  - Each cycle with iwait=0: data[idx][counter] <= iload, counter+1.
  - On the last word (counter=2^BLK_W-1, iwait=0): write the tag, set valid, go to IDLE. iREN=0 next cycle.
  - ihit=0 throughout FILL. The requested word hits in IDLE one cycle after the last word is accepted.
- Miss latency: 1 (decision cycle) + sum of per-word memory latencies + 1 (hit cycle).
- Inputs changing during FILL:
  - imemREN dropped or imemaddr changed: the fill completes for the latched address.
  - The new address is evaluated in IDLE afterwards and may miss again.
- iflush:
  - Takes priority over everything. All valids are cleared at the next edge.
  - In FILL: the fill is aborted, state returns to IDLE, iREN=0 next cycle, and the partial line stays invalid.
  - The cycle iflush=1 never produces ihit and never starts a fill.
- Counters:
  - hit_cnt increments every cycle ihit=1.
  - miss_cnt increments on each IDLE->FILL transition.
  - Both saturate at all-ones and never wrap.
- BLK_W=0: single-word fill. The counter is unused and iaddr={tag, idx, BYT_W'0}.
- Write port: none; the instruction cache is read-only. Self-modifying code requires iflush.

Test Plan:
1. Defaults, reset, imemREN=1, imemaddr=0x40, memory latency 2 -> iREN=1 with iaddr=0x40 then 0x44. ihit=1 one cycle after the 0x44 word, imemload=mem[0x40], miss_cnt=1, hit_cnt=1.
2. Then imemaddr=0x44 -> ihit=1 same cycle, imemload=mem[0x44], iREN=0, hit_cnt=2.
3. Conflict: imemaddr=0x440 (idx 8, like 0x40) -> miss, refill 0x440/0x444. Then 0x40 misses again; miss_cnt=3.
4. iflush=1 on the 2nd FILL cycle of 0x80 -> iREN=0 next cycle, state IDLE. 0x40 and 0x80 both miss afterwards; no spurious ihit.
5. BLK_W=0, IDX_W=3 instance, imemaddr=0x10 -> single iaddr=0x10 request. Then hit at 0x10; 0x14 misses (different set).
6. CNT_W=4, one fill then 20 consecutive hit cycles on 0x40 -> hit_cnt=15 (saturated), miss_cnt=1. nRST low mid-test -> all outputs 0 immediately.
